wb_imem_loader: RTL and testbench

- Wishbone slave that sits directly upstream of the RISC_V core inside user_project_wrapper.
- Lets the management SoC load program words into the core's instruction memory and read them back.
- Holds the core in reset while loading, then releases it to run.
- While the core runs, the block multiplexes the instruction-memory port to the core's fetch PC.

---
 rtl/wb_imem_loader_if.sv | 27 ++
 rtl/wb_imem_loader.sv | 200 ++++++++++++++++++++
 tb/tb_wb_imem_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_imem_loader_if.sv
// rtl/wb_imem_loader_if.sv - Wishbone slave bus bundle for the instruction-memory loader
// Purpose: groups the Wishbone strobe/cycle/address/data/ack signals.
// Ports (signals):
//   wbs_stb_i, wbs_cyc_i, wbs_we_i  : strobe, cycle, write enable (master -> slave)
//   wbs_sel_i[3:0]                  : byte selects (master -> slave)
//   wbs_adr_i[31:0], wbs_dat_i[31:0]: byte address, write data (master -> slave)
//   wbs_ack_o, wbs_dat_o[31:0]      : acknowledge, read data (slave -> master)
interface wb_imem_loader_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_imem_loader.sv
// rtl/wb_imem_loader.sv - Wishbone loader for the RISC-V core instruction memory
// Purpose: lets the management SoC write/read instruction memory while the core
// is held in reset, then releases the core and hands the memory port to its PC.
// Ports:
//   wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//   wbs                 : Wishbone slave bus (registers CTRL/PTR/DATA/STATUS)
//   core_rst_n_o        : registered active-low core reset
//   core_pc_i           : core fetch word address, drives memory while running
//   imem_we_o, imem_addr_o, imem_wdata_o, imem_rdata_i : instruction-memory port
module wb_imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_W    = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    wb_imem_loader_if.slave   wbs,
    output logic              core_rst_n_o,
    input  logic [ADDR_W-1:0] core_pc_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    input  logic [31:0]       imem_rdata_i
);
    typedef enum logic [2:0] {IDLE, WACK, RWAIT, RACK, RUN} state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PTR    = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    state_t            state, state_d;
    logic [1:0]        ctrl, ctrl_d;
    logic [ADDR_W-1:0] ptr, ptr_d, cnt, cnt_d, addr_q, addr_d;
    logic              err, err_d, we_d, from_mem, from_mem_d, pend, pend_d;
    logic              ack_d, core_rst_d;
    logic [31:0]       wdata_q, wdata_d, rd_q, rd_d, dat_d, reg_rdata;
    logic [ADDR_W-1:0] ptr_inc, cnt_inc;
    logic              sel_hit, full_sel, bus_live;
    logic [1:0]        reg_idx;
    logic [1:0]        unused_adr;

    assign unused_adr = wbs.wbs_adr_i[1:0];
    assign bus_live   = wbs.wbs_stb_i & wbs.wbs_cyc_i;
    // The ack cycle itself must not be taken as the start of a new access.
    assign sel_hit  = bus_live & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs.wbs_ack_o;
    assign full_sel = (wbs.wbs_sel_i == 4'hF);
    assign reg_idx  = wbs.wbs_adr_i[3:2];
    assign ptr_inc  = ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign cnt_inc  = (cnt == {ADDR_W{1'b1}}) ? cnt : cnt + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        reg_rdata = 32'h0;
        case (reg_idx)
            REG_CTRL:   reg_rdata = {30'h0, ctrl};
            REG_PTR:    reg_rdata = {{(32-ADDR_W){1'b0}}, ptr};
            REG_STATUS: reg_rdata = {{(30-ADDR_W){1'b0}}, cnt, err, state == RUN};
            default:    reg_rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state;
        ctrl_d     = ctrl;
        ptr_d      = ptr;
        err_d      = err;
        cnt_d      = cnt;
        addr_d     = addr_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        from_mem_d = from_mem;
        pend_d     = 1'b0;
        ack_d      = 1'b0;
        dat_d      = 32'h0;
        case (state)
            IDLE: begin
                if (sel_hit) begin
                    if (wbs.wbs_we_i) begin
                        state_d = WACK;
                        if (full_sel) begin
                            case (reg_idx)
                                REG_CTRL: begin
                                    ctrl_d = wbs.wbs_dat_i[1:0];
                                    if (wbs.wbs_dat_i[31]) err_d = 1'b0;
                                end
                                REG_PTR: begin
                                    ptr_d = wbs.wbs_dat_i[ADDR_W-1:0];
                                    cnt_d = '0;
                                end
                                REG_DATA: begin
                                    we_d    = 1'b1;
                                    addr_d  = ptr;
                                    wdata_d = wbs.wbs_dat_i;
                                    if (ctrl[1]) begin
                                        ptr_d = ptr_inc;
                                        cnt_d = cnt_inc;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else if (reg_idx == REG_DATA) begin
                        addr_d     = ptr;
                        from_mem_d = 1'b1;
                        if (ctrl[1]) ptr_d = ptr_inc;
                        state_d    = RWAIT;
                    end else begin
                        rd_d       = reg_rdata;
                        from_mem_d = 1'b0;
                        state_d    = RACK;
                    end
                end
            end
            WACK: begin
                ack_d   = bus_live;
                state_d = ctrl[0] ? RUN : IDLE;
            end
            // Memory samples the address this cycle; its output is valid in RACK.
            RWAIT: state_d = RACK;
            RACK: begin
                ack_d   = bus_live;
                dat_d   = bus_live ? (from_mem ? imem_rdata_i : rd_q) : 32'h0;
                state_d = IDLE;
            end
            RUN: begin
                if (pend) begin
                    // Second cycle of a run-time access: ack without leaving RUN.
                    ack_d = bus_live;
                    dat_d = bus_live ? rd_q : 32'h0;
                end else if (sel_hit) begin
                    pend_d = 1'b1;
                    rd_d   = 32'h0;
                    if (wbs.wbs_we_i) begin
                        if (full_sel) begin
                            case (reg_idx)
                                REG_CTRL: begin
                                    ctrl_d = wbs.wbs_dat_i[1:0];
                                    if (wbs.wbs_dat_i[31]) err_d = 1'b0;
                                    if (!wbs.wbs_dat_i[0]) begin
                                        pend_d  = 1'b0;
                                        state_d = WACK;
                                    end
                                end
                                REG_PTR: begin
                                    ptr_d = wbs.wbs_dat_i[ADDR_W-1:0];
                                    cnt_d = '0;
                                end
                                REG_DATA: err_d = 1'b1;
                                default: ;
                            endcase
                        end
                    end else if (reg_idx == REG_DATA) begin
                        err_d = 1'b1;
                    end else begin
                        rd_d = reg_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        core_rst_d = (state == RUN) && (state_d == RUN);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state         <= IDLE;
            ctrl          <= '0;
            ptr           <= '0;
            err           <= 1'b0;
            cnt           <= '0;
            addr_q        <= '0;
            imem_we_o     <= 1'b0;
            wdata_q       <= 32'h0;
            rd_q          <= 32'h0;
            from_mem      <= 1'b0;
            pend          <= 1'b0;
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= 32'h0;
            core_rst_n_o  <= 1'b0;
        end else begin
            state         <= state_d;
            ctrl          <= ctrl_d;
            ptr           <= ptr_d;
            err           <= err_d;
            cnt           <= cnt_d;
            addr_q        <= addr_d;
            imem_we_o     <= we_d;
            wdata_q       <= wdata_d;
            rd_q          <= rd_d;
            from_mem      <= from_mem_d;
            pend          <= pend_d;
            wbs.wbs_ack_o <= ack_d;
            wbs.wbs_dat_o <= dat_d;
            core_rst_n_o  <= core_rst_d;
        end
    end

    assign imem_addr_o  = (state == RUN) ? core_pc_i : addr_q;
    assign imem_wdata_o = wdata_q;
endmodule

// File: tb/tb_wb_imem_loader.sv
// tb/tb_wb_imem_loader.sv - directed self-checking bench for wb_imem_loader
module tb_wb_imem_loader;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_rst_n;
    logic [7:0]  core_pc = 8'h00;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic [31:0] mem [0:255];
    int          we_cycles = 0;
    int          errs = 0;
    int          checks = 0;
    logic [31:0] rd;
    int          lat;
    logic        saw_ack;

    always #5 clk = ~clk;

    wb_imem_loader_if wbs ();

    wb_imem_loader #(.BASE_ADDR(32'h3000_0000), .ADDR_W(8)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs          (wbs),
        .core_rst_n_o (core_rst_n),
        .core_pc_i    (core_pc),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .imem_rdata_i (imem_rdata)
    );

    always @(posedge clk) begin
        if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            we_cycles      <= we_cycles + 1;
        end
        imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rdata, output int l);
        @(posedge clk); #1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_we_i  = we;
        wbs.wbs_adr_i = a;
        wbs.wbs_dat_i = d;
        wbs.wbs_sel_i = s;
        l = 0;
        do begin
            @(posedge clk); #1;
            l++;
        end while (!wbs.wbs_ack_o && l < 10);
        rdata = wbs.wbs_dat_o;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] d);
        logic [31:0] r;
        int l;
        wb_access(1'b1, BASE + off, d, 4'hF, r, l);
        check({tag, ".lat"}, 32'(l), 32'd2);
    endtask

    task automatic rdchk(input string tag, input logic [31:0] off, input logic [31:0] exp,
                         input int exp_lat);
        logic [31:0] r;
        int l;
        wb_access(1'b0, BASE + off, 32'h0, 4'hF, r, l);
        check({tag, ".lat"}, 32'(l), 32'(exp_lat));
        check({tag, ".data"}, r, exp);
    endtask

    initial begin
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_sel_i = 4'h0;
        wbs.wbs_adr_i = 32'h0;
        wbs.wbs_dat_i = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.ack", {31'h0, wbs.wbs_ack_o}, 32'h0);
        check("rst.dat", wbs.wbs_dat_o, 32'h0);
        check("rst.core_rst", {31'h0, core_rst_n}, 32'h0);
        check("rst.we", {31'h0, imem_we}, 32'h0);
        check("rst.addr", {24'h0, imem_addr}, 32'h0);
        rst_n = 1'b1;

        rdchk("status0", 32'hC, 32'h0, 2);
        check("core_rst.load0", {31'h0, core_rst_n}, 32'h0);

        // Load two words with auto-increment
        wr("ctrl_ai", 32'h0, 32'h2);
        wr("ptr10", 32'h4, 32'h10);
        wr("data0", 32'h8, 32'h0050_0093);
        wr("data1", 32'h8, 32'h0010_0113);
        repeat (2) @(posedge clk);
        #1;
        check("mem10", mem[8'h10], 32'h0050_0093);
        check("mem11", mem[8'h11], 32'h0010_0113);
        check("we_cycles2", 32'(we_cycles), 32'd2);
        rdchk("status_cnt2", 32'hC, 32'h8, 2);
        rdchk("ptr12", 32'h4, 32'h12, 2);
        rdchk("ctrl2", 32'h0, 32'h2, 2);
        check("core_rst.load1", {31'h0, core_rst_n}, 32'h0);

        // Read back through DATA
        wr("ptr10b", 32'h4, 32'h10);
        rdchk("rdata0", 32'h8, 32'h0050_0093, 3);
        rdchk("rdata1", 32'h8, 32'h0010_0113, 3);
        rdchk("status_cnt0", 32'hC, 32'h0, 2);
        rdchk("ptr12b", 32'h4, 32'h12, 2);

        // Strobe dropped mid-read: sequence completes silently
        @(posedge clk); #1;
        wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1; wbs.wbs_we_i = 1'b0;
        wbs.wbs_adr_i = BASE + 32'h8; wbs.wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            saw_ack = saw_ack | wbs.wbs_ack_o;
        end
        check("stb_drop.noack", {31'h0, saw_ack}, 32'h0);

        // Pointer wrap at the top of memory
        wr("ptrff", 32'h4, 32'hFF);
        wr("dataff", 32'h8, 32'hDEAD_BEEF);
        repeat (2) @(posedge clk);
        #1;
        check("memff", mem[8'hFF], 32'hDEAD_BEEF);
        check("we_cycles3", 32'(we_cycles), 32'd3);
        rdchk("ptr_wrap", 32'h4, 32'h0, 2);
        rdchk("status_cnt1", 32'hC, 32'h4, 2);

        // Partial byte-select write is ignored but acked
        wb_access(1'b1, BASE + 32'h4, 32'h55, 4'h3, rd, lat);
        check("sel3.lat", 32'(lat), 32'd2);
        rdchk("ptr_sel3", 32'h4, 32'h0, 2);

        // Run the core
        wr("ctrl_run", 32'h0, 32'h1);
        check("run.core_rst_at_ack", {31'h0, core_rst_n}, 32'h0);
        @(posedge clk); #1;
        check("run.core_rst", {31'h0, core_rst_n}, 32'h1);
        core_pc = 8'h23;
        #1;
        check("run.addr_pc", {24'h0, imem_addr}, 32'h23);
        rdchk("run.status", 32'hC, 32'h5, 2);
        wr("run.data_wr", 32'h8, 32'h1234_5678);
        repeat (2) @(posedge clk);
        #1;
        check("run.no_we", 32'(we_cycles), 32'd3);
        rdchk("run.status_err", 32'hC, 32'h7, 2);
        rdchk("run.data_rd", 32'h8, 32'h0, 2);
        rdchk("run.ctrl", 32'h0, 32'h1, 2);
        wr("run.stop", 32'h0, 32'h8000_0000);
        check("stop.core_rst", {31'h0, core_rst_n}, 32'h0);
        rdchk("stop.status", 32'hC, 32'h4, 2);

        // Asynchronous reset during RWAIT
        wr("ctrl_ai2", 32'h0, 32'h2);
        wr("ptr30", 32'h4, 32'h30);
        @(posedge clk); #1;
        wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1; wbs.wbs_we_i = 1'b0;
        wbs.wbs_adr_i = BASE + 32'h8; wbs.wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        check("rwait.addr", {24'h0, imem_addr}, 32'h30);
        check("rwait.ptr_inc", {24'h0, dut.ptr}, 32'h31);
        rst_n = 1'b0;
        #1;
        check("arst.ack", {31'h0, wbs.wbs_ack_o}, 32'h0);
        check("arst.core_rst", {31'h0, core_rst_n}, 32'h0);
        check("arst.ptr", {24'h0, dut.ptr}, 32'h0);
        check("arst.addr", {24'h0, imem_addr}, 32'h0);
        saw_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            saw_ack = saw_ack | wbs.wbs_ack_o;
        end
        check("arst.noack", {31'h0, saw_ack}, 32'h0);
        wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0;
        rst_n = 1'b1;
        rdchk("post_rst.ptr", 32'h4, 32'h0, 2);
        rdchk("post_rst.ctrl", 32'h0, 32'h0, 2);
        rdchk("post_rst.status", 32'hC, 32'h0, 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
